// File: rtl/elastic_buffer_pkg.sv
// Shared definitions for the stream-buffer family: handshake signal widths
// and a constant-evaluable ceiling-log2 used to size pointers and counters.
package elastic_buffer_pkg;

    // Width of the valid and ready handshake signals on every stream port.
    localparam int HS_VLD_W = 1;
    localparam int HS_RDY_W = 1;

    // Smallest n with 2**n >= value; eb_clog2(1) == 0.
    function automatic int eb_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/elastic_buffer_mem.sv
// Entry storage for elastic_buffer: a DEPTH x DATA_W flop array with one
// synchronous write port and one asynchronous read port. Contents are
// deliberately left unreset; the control block masks them with o_vld.
module elastic_buffer_mem
    import elastic_buffer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [eb_clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [eb_clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Capture the accepted upstream word into the slot at the write pointer.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/elastic_buffer.sv
// Elastic (skid/FIFO) buffer between two valid/ready stream interfaces.
//
// Handshake: a word moves across an interface in any cycle where both its
// valid and its ready are high at the rising edge. Valid, once high, is not
// withdrawn by this block until the word is taken (or a flush/reset clears
// the buffer); data is stable for as long as valid waits on ready.
//
// o_rdy comes straight from a flop holding (next occupancy < DEPTH), so the
// upstream ready path never sees i_rdy or i_vld combinationally. o_vld and
// o_data derive only from registered state, so there is no flow-through from
// i_data: a word written into an empty buffer shows up one cycle later.
module elastic_buffer
    import elastic_buffer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_vld,
    input  logic [DATA_W-1:0]            i_data,
    output logic                         o_rdy,
    output logic                         o_vld,
    output logic [DATA_W-1:0]            o_data,
    input  logic                         i_rdy,
    output logic [eb_clog2(DEPTH+1)-1:0] o_count,
    output logic                         o_empty,
    output logic                         o_afull
);

    localparam int PTR_W = eb_clog2(DEPTH);
    localparam int CNT_W = eb_clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             rdy_q;
    logic             push;
    logic             pop;
    logic             mem_we;

    // A transfer happens on each side only when both halves of its handshake agree.
    assign push = i_vld && rdy_q;
    assign pop  = (count != '0) && i_rdy;

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two;
    // the separate counter disambiguates full from empty.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Pointer, occupancy and ready registers; reset outranks flush, flush outranks traffic.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b1;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            rdy_q <= (count_nxt < CNT_W'(DEPTH));
        end
    end

    // Words offered during a flush or reset cycle are dropped, so never written.
    assign mem_we = push && !i_flush && !i_rst;

    elastic_buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (wr_ptr),
        .i_wdata (i_data),
        .i_raddr (rd_ptr),
        .o_rdata (o_data)
    );

    assign o_rdy   = rdy_q;
    assign o_vld   = (count != '0);
    assign o_count = count;
    assign o_empty = (count == '0);
    assign o_afull = (count >= CNT_W'(AFULL_LVL));

endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer. Instance a (DEPTH=4) carries the directed
// scenarios, instance b (DEPTH=8) the long random run. Each instance has a
// reference queue: words are pushed on accepted input, popped and compared
// when the DUT presents them.
module tb_elastic_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance a: DEPTH=4, AFULL_LVL=3
    logic       a_flush;
    logic       a_vld;
    logic [7:0] a_data;
    logic       a_o_rdy;
    logic       a_o_vld;
    logic [7:0] a_o_data;
    logic       a_rdy;
    logic [2:0] a_o_count;
    logic       a_o_empty;
    logic       a_o_afull;

    // Instance b: DEPTH=8, AFULL_LVL=7
    logic       b_flush;
    logic       b_vld;
    logic [7:0] b_data;
    logic       b_o_rdy;
    logic       b_o_vld;
    logic [7:0] b_o_data;
    logic       b_rdy;
    logic [3:0] b_o_count;
    logic       b_o_empty;
    logic       b_o_afull;

    elastic_buffer #(.DATA_W(8), .DEPTH(4)) dut_a (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (a_flush),
        .i_vld   (a_vld),
        .i_data  (a_data),
        .o_rdy   (a_o_rdy),
        .o_vld   (a_o_vld),
        .o_data  (a_o_data),
        .i_rdy   (a_rdy),
        .o_count (a_o_count),
        .o_empty (a_o_empty),
        .o_afull (a_o_afull)
    );

    elastic_buffer #(.DATA_W(8), .DEPTH(8)) dut_b (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (b_flush),
        .i_vld   (b_vld),
        .i_data  (b_data),
        .o_rdy   (b_o_rdy),
        .o_vld   (b_o_vld),
        .o_data  (b_o_data),
        .i_rdy   (b_rdy),
        .o_count (b_o_count),
        .o_empty (b_o_empty),
        .o_afull (b_o_afull)
    );

    logic [7:0] exp_q[$];
    logic [7:0] exp_q8[$];
    logic       m_rdy;
    logic       m_rdy8;
    int         checks = 0;
    int         errors = 0;

    // One clock of instance a: drive inputs, compare outputs against the
    // reference, advance the reference, then step to #1 after the next edge.
    task automatic cycle_a(input logic vld, input logic [7:0] data,
                           input logic rdy, input logic flush);
        logic m_vld;
        a_vld   = vld;
        a_data  = data;
        a_rdy   = rdy;
        a_flush = flush;
        m_vld   = (exp_q.size() != 0);
        checks++;
        if (a_o_vld !== m_vld) begin
            errors++;
            $display("FAIL a_vld: got %b expected %b", a_o_vld, m_vld);
        end
        checks++;
        if (a_o_rdy !== m_rdy) begin
            errors++;
            $display("FAIL a_rdy: got %b expected %b", a_o_rdy, m_rdy);
        end
        checks++;
        if (a_o_count !== 3'(exp_q.size())) begin
            errors++;
            $display("FAIL a_count: got %0d expected %0d", a_o_count, exp_q.size());
        end
        checks++;
        if (a_o_empty !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL a_empty: got %b expected %b", a_o_empty, exp_q.size() == 0);
        end
        checks++;
        if (a_o_afull !== (exp_q.size() >= 3)) begin
            errors++;
            $display("FAIL a_afull: got %b expected %b", a_o_afull, exp_q.size() >= 3);
        end
        if (m_vld) begin
            checks++;
            if (a_o_data !== exp_q[0]) begin
                errors++;
                $display("FAIL a_data: got %h expected %h", a_o_data, exp_q[0]);
            end
        end
        if (flush) begin
            exp_q.delete();
            m_rdy = 1'b1;
        end else begin
            if (m_vld && rdy) void'(exp_q.pop_front());
            if (vld && m_rdy) exp_q.push_back(data);
            m_rdy = (exp_q.size() < 4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_vld = 1'b0; a_data = '0; a_rdy = 1'b0; a_flush = 1'b0;
        b_vld = 1'b0; b_data = '0; b_rdy = 1'b0; b_flush = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_q8.delete();
        m_rdy  = 1'b1;
        m_rdy8 = 1'b1;
        checks++;
        if (a_o_rdy !== 1'b1 || a_o_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: got rdy=%b vld=%b expected rdy=1 vld=0", a_o_rdy, a_o_vld);
        end
        checks++;
        if (a_o_count !== 3'd0 || a_o_empty !== 1'b1 || a_o_afull !== 1'b0) begin
            errors++;
            $display("FAIL reset_occ: got count=%0d empty=%b afull=%b expected 0/1/0",
                     a_o_count, a_o_empty, a_o_afull);
        end
        checks++;
        if (b_o_rdy !== 1'b1 || b_o_vld !== 1'b0 || b_o_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_b: got rdy=%b vld=%b count=%0d expected 1/0/0",
                     b_o_rdy, b_o_vld, b_o_count);
        end
    endtask

    // Fill to full with the consumer stalled, then drain in order.
    task automatic test_fill_drain();
        logic [7:0] words [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) cycle_a(1'b1, words[i], 1'b0, 1'b0);
        checks++;
        if (a_o_count !== 3'd4 || a_o_rdy !== 1'b0 || a_o_afull !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got count=%0d rdy=%b afull=%b expected 4/0/1",
                     a_o_count, a_o_rdy, a_o_afull);
        end
        for (int i = 0; i < 4; i++) cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (a_o_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got %b expected 1", a_o_empty);
        end
    endtask

    // Continuous flow: 20 words, occupancy should sit at one after the first.
    task automatic test_stream();
        for (int i = 0; i < 20; i++) cycle_a(1'b1, 8'(i), 1'b1, 1'b0);
        checks++;
        if (a_o_count !== 3'd1) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 1", a_o_count);
        end
        cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
        cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Full buffer with a pop and an offered word: pop happens, word is refused.
    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) cycle_a(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
        cycle_a(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if (a_o_rdy !== 1'b1 || a_o_count !== 3'd3) begin
            errors++;
            $display("FAIL full_pop: got rdy=%b count=%0d expected 1/3", a_o_rdy, a_o_count);
        end
        for (int i = 0; i < 4; i++) cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Flush with three stored words and a word offered in the flush cycle.
    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle_a(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle_a(1'b1, 8'h99, 1'b1, 1'b1);
        checks++;
        if (a_o_count !== 3'd0 || a_o_vld !== 1'b0 || a_o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL flush: got count=%0d vld=%b rdy=%b expected 0/0/1",
                     a_o_count, a_o_vld, a_o_rdy);
        end
        for (int i = 0; i < 3; i++) cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
        cycle_a(1'b1, 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Reset with two stored words and a word offered in the reset cycle.
    task automatic test_reset_mid();
        cycle_a(1'b1, 8'h61, 1'b0, 1'b0);
        cycle_a(1'b1, 8'h62, 1'b0, 1'b0);
        a_vld = 1'b1; a_data = 8'h77; a_rdy = 1'b1; a_flush = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_flush = 1'b0;
        exp_q.delete();
        m_rdy = 1'b1;
        checks++;
        if (a_o_vld !== 1'b0 || a_o_count !== 3'd0 || a_o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got vld=%b count=%0d rdy=%b expected 0/0/1",
                     a_o_vld, a_o_count, a_o_rdy);
        end
        cycle_a(1'b1, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Random 50% valid/ready on the DEPTH=8 instance with full reference checks.
    task automatic test_random();
        logic       vld;
        logic       rdy;
        logic       m_vld;
        logic [7:0] data;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            vld   = 1'($urandom_range(0, 1));
            rdy   = 1'($urandom_range(0, 1));
            data  = 8'($urandom_range(0, 255));
            b_vld = vld;
            b_rdy = rdy;
            b_data = data;
            m_vld = (exp_q8.size() != 0);
            checks++;
            if (b_o_vld !== m_vld || b_o_rdy !== m_rdy8) begin
                errors++;
                $display("FAIL rand_hs cyc %0d: got vld=%b rdy=%b expected vld=%b rdy=%b",
                         cyc, b_o_vld, b_o_rdy, m_vld, m_rdy8);
            end
            checks++;
            if (b_o_count !== 4'(exp_q8.size()) || b_o_afull !== (exp_q8.size() >= 7)
                || b_o_empty !== (exp_q8.size() == 0)) begin
                errors++;
                $display("FAIL rand_occ cyc %0d: got count=%0d afull=%b empty=%b expected count=%0d",
                         cyc, b_o_count, b_o_afull, b_o_empty, exp_q8.size());
            end
            if (m_vld) begin
                checks++;
                if (b_o_data !== exp_q8[0]) begin
                    errors++;
                    $display("FAIL rand_data cyc %0d: got %h expected %h", cyc, b_o_data, exp_q8[0]);
                end
            end
            if (m_vld && rdy) void'(exp_q8.pop_front());
            if (vld && m_rdy8) exp_q8.push_back(data);
            m_rdy8 = (exp_q8.size() < 8);
            @(posedge clk);
            #1;
        end
        b_vld = 1'b0;
        b_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_full_pop();
        test_flush();
        test_reset_mid();
        test_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elastic_buffer.md
ELASTIC_BUFFER -- requirements
Module: elastic_buffer

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, storage entries; power of two, >=2.
REQ-003 Parameter AFULL_LVL, default DEPTH-1, occupancy at or above which o_afull asserts (1..DEPTH).
REQ-004 i_clk  in  1  clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_flush  in  1  synchronous discard of all stored entries.
REQ-007 i_vld  in  1  upstream data valid.
REQ-008 i_data  in  DATA_W  upstream payload.
REQ-009 o_rdy  out  1  ready to upstream; registered.
REQ-010 o_vld  out  1  valid to downstream.
REQ-011 o_data  out  DATA_W  payload to downstream (head entry).
REQ-012 i_rdy  in  1  downstream ready.
REQ-013 o_count  out  $clog2(DEPTH+1)  current occupancy.
REQ-014 o_empty  out  1  occupancy == 0.
REQ-015 o_afull  out  1  occupancy >= AFULL_LVL.

Function
REQ-016 Push = i_vld && o_rdy; pop = o_vld && i_rdy; both evaluated in the same cycle.
REQ-017 Order preserved: entries leave in exactly the order accepted; no loss, no duplication.
REQ-018 o_rdy driven directly from a flop equal to (next occupancy < DEPTH); no combinational path from i_rdy or i_vld to o_rdy.
REQ-019 o_vld = (occupancy > 0); o_data = entry at read pointer; no combinational path from i_data/i_vld to o_vld/o_data.
REQ-020 Latency: an entry pushed into an empty buffer appears on o_vld/o_data the following cycle (1-cycle latency, no bypass).
REQ-021 Throughput: with i_vld and i_rdy continuously high, one transfer per cycle sustained at any occupancy 1..DEPTH-1.
REQ-022 Full (occupancy == DEPTH): o_rdy = 0; a pop that cycle raises o_rdy the next cycle; the full-cycle i_vld is not accepted.
REQ-023 Empty: o_vld = 0, o_data holds last value (don't care to downstream); push-only that cycle -> occupancy 1.
REQ-024 Simultaneous push and pop: occupancy unchanged; both pointers advance.
REQ-025 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy tracked by a separate counter.
REQ-026 While o_vld && !i_rdy, o_vld and o_data remain stable next cycle unless i_flush.
REQ-027 i_flush: next cycle occupancy 0, pointers 0, o_rdy = 1, o_vld = 0; push/pop in the flush cycle are discarded; flush takes priority over push/pop.
REQ-028 o_count, o_empty, o_afull reflect registered occupancy (same cycle as o_vld).

Reset
REQ-029 On i_rst: occupancy 0, pointers 0, o_rdy = 1 after first reset cycle, o_vld = 0, o_empty = 1, o_afull = 0, o_count = 0.
REQ-030 Storage array is not reset; o_data value is don't care while o_vld = 0.
REQ-031 i_rst mid-transfer discards all content; i_rst has priority over i_flush.

Structure
REQ-032 A shared package/header holds the clog2 helper and the handshake-width constants used by this and sibling stream blocks.
REQ-033 Storage implemented as sub-module elastic_buffer_mem (DEPTH x DATA_W flop array, one write port, one async read port); control stays in elastic_buffer.

Verification
REQ-034 Formal: shadow-FIFO model proves order (REQ-017), occupancy <= DEPTH, o_rdy stability (REQ-018), output stability (REQ-026); upstream assumed legal (hold i_vld/i_data while !o_rdy).
REQ-035 DEPTH=4: push 0x11,0x22,0x33,0x44 with i_rdy=0 -> o_count=4, o_rdy=0, o_afull=1 from count 3; then i_rdy=1 -> outputs 0x11..0x44 in order on 4 consecutive cycles.
REQ-036 Streaming: i_vld=i_rdy=1 for 20 cycles, data 0..19 -> output 0..19, one per cycle after 1-cycle latency, o_count constant 1.
REQ-037 Full with simultaneous pop: count=4, i_vld=1, i_rdy=1 -> 0x11 popped, new data not accepted, next cycle o_rdy=1, count=3.
REQ-038 Flush: count=3, assert i_flush with i_vld=1 -> next cycle count=0, o_vld=0, o_rdy=1, no flushed or flush-cycle data ever appears.
REQ-039 Reset mid-stream: i_rst at count=2 -> next cycle o_vld=0, o_count=0, o_rdy=1; subsequent push 0xA5 emerges alone.
REQ-040 Random i_vld/i_rdy (50%) with DEPTH=8, 10k cycles -> scoreboard match, zero mismatches.
